rle_stream_encoder: RTL and testbench

Parametrised streaming run-length encoder. It accepts a valid/ready stream of DATA_W-bit symbols and emits {count, value} pairs on a valid/ready output stream. Frames are delimited by in_last or an explicit flush. Runs saturate at the count maximum. An internal pair FIFO absorbs output backpressure. It supersedes the fixed 8/8-bit RAM-mapped encoder for pipelines that need wider symbols and streaming I/O.

---
 rtl/rle_pkg.sv | 20 ++
 rtl/rle_pair_fifo.sv | 66 ++++++
 rtl/rle_stream_encoder.sv | 169 ++++++++++++++++
 tb/tb_rle_stream_encoder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared types and sizing helpers for the streaming run-length encoder.
package rle_pkg;

   // Encoder state: no open run, or a run being counted.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } rle_state_e;

   // Pair layout, MSB first: {last, count[cnt_w], value[data_w]}.
   function automatic int pair_w_f(input int cnt_w, input int data_w);
      return cnt_w + data_w + 1;
   endfunction

   // Largest count a run may reach before it is split.
   function automatic int max_run_f(input int cnt_w);
      return (1 << cnt_w) - 1;
   endfunction

endpackage

// File: rtl/rle_pair_fifo.sv
// Pair FIFO: up to two writes and one read per cycle, with a free-entry count.
module rle_pair_fifo
   import rle_pkg::*;
#(
   parameter int WIDTH = 17,
   parameter int DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [1:0]                push_n_i,
   input  logic [WIDTH-1:0]          wdata0_i,
   input  logic [WIDTH-1:0]          wdata1_i,
   input  logic                      pop_i,
   output logic [WIDTH-1:0]          rdata_o,
   output logic                      empty_o,
   output logic [$clog2(DEPTH):0]    free_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             pop_s;

   assign pop_s   = pop_i && (count_q != '0);
   assign rdata_o = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign free_o  = (AW+1)'(DEPTH) - count_q;

   // Storage writes: the first write port always lands before the second.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         case (push_n_i)
            2'd1: begin
               mem_q[wr_ptr_q] <= wdata0_i;
            end
            2'd2: begin
               mem_q[wr_ptr_q]           <= wdata0_i;
               mem_q[wr_ptr_q + AW'(1)]  <= wdata1_i;
            end
            default: begin
            end
         endcase
      end
   end

   // Pointer and occupancy bookkeeping; push and pop may coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + AW'(push_n_i);
         rd_ptr_q <= rd_ptr_q + AW'(pop_s);
         count_q  <= count_q + (AW+1)'(push_n_i) - (AW+1)'(pop_s);
      end
   end

endmodule

// File: rtl/rle_stream_encoder.sv
// Streaming run-length encoder: symbols in, {count, value} pairs out.
module rle_stream_encoder
   import rle_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int CNT_W      = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_data,
   input  logic                    in_last,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CNT_W+DATA_W-1:0] out_data,
   output logic                    out_last,
   output logic [15:0]             pair_cnt
);

   localparam int PW = pair_w_f(CNT_W, DATA_W);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(max_run_f(CNT_W));
   localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

   rle_state_e        state_q, state_d;
   logic [DATA_W-1:0] run_val_q, run_val_d;
   logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
   logic              in_ready_q;
   logic [15:0]       pair_cnt_q;

   logic [1:0]        push_n_s;
   logic [PW-1:0]     pair0_s;
   logic [PW-1:0]     pair1_s;
   logic [PW-1:0]     head_s;
   logic              empty_s;
   logic [AW:0]       free_s;
   logic [AW+1:0]     free_next_s;
   logic              accept_s;
   logic              last_s;
   logic              pop_s;

   function automatic logic [PW-1:0] pack_pair(input logic last,
                                                input logic [CNT_W-1:0] cnt,
                                                input logic [DATA_W-1:0] val);
      return {last, cnt, val};
   endfunction

   assign accept_s  = in_valid && in_ready_q;
   assign last_s    = in_last || flush;
   assign pop_s     = !empty_s && out_ready;
   assign in_ready  = in_ready_q;
   assign out_valid = !empty_s;
   assign out_last  = head_s[PW-1];
   assign out_data  = head_s[PW-2:0];
   assign pair_cnt  = pair_cnt_q;

   // Free entries after this cycle's pushes and pop; two are needed per beat.
   assign free_next_s = (AW+2)'(free_s) + (AW+2)'(pop_s) - (AW+2)'(push_n_s);

   // Run tracking: decide the next run and which pairs to emit this cycle.
   always_comb begin
      state_d   = state_q;
      run_val_d = run_val_q;
      run_cnt_d = run_cnt_q;
      push_n_s  = 2'd0;
      pair0_s   = '0;
      pair1_s   = '0;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               if (last_s) begin
                  push_n_s = 2'd1;
                  pair0_s  = pack_pair(1'b1, ONE_CNT, in_data);
               end else begin
                  state_d   = RUN;
                  run_val_d = in_data;
                  run_cnt_d = ONE_CNT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (accept_s) begin
               if ((in_data == run_val_q) && (run_cnt_q != MAX_CNT)) begin
                  // Run continues; a last beat closes it including this symbol.
                  if (last_s) begin
                     push_n_s  = 2'd1;
                     pair0_s   = pack_pair(1'b1, run_cnt_q + ONE_CNT, in_data);
                     state_d   = IDLE;
                     run_cnt_d = '0;
                  end else begin
                     run_cnt_d = run_cnt_q + ONE_CNT;
                  end
               end else begin
                  // Saturated or changed symbol: close the run, open a new one.
                  pair0_s = pack_pair(1'b0, run_cnt_q, run_val_q);
                  if (last_s) begin
                     push_n_s  = 2'd2;
                     pair1_s   = pack_pair(1'b1, ONE_CNT, in_data);
                     state_d   = IDLE;
                     run_cnt_d = '0;
                  end else begin
                     push_n_s  = 2'd1;
                     run_val_d = in_data;
                     run_cnt_d = ONE_CNT;
                  end
               end
            end else if (flush) begin
               push_n_s  = 2'd1;
               pair0_s   = pack_pair(1'b1, run_cnt_q, run_val_q);
               state_d   = IDLE;
               run_cnt_d = '0;
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d   = IDLE;
            run_cnt_d = '0;
         end
      endcase
   end

   // Encoder state, run registers and registered input-ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         run_val_q  <= '0;
         run_cnt_q  <= '0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         run_val_q  <= run_val_d;
         run_cnt_q  <= run_cnt_d;
         in_ready_q <= (free_next_s >= (AW+2)'(2));
      end
   end

   // Count of pairs handed to the consumer; wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pair_cnt_q <= 16'd0;
      end else if (pop_s) begin
         pair_cnt_q <= pair_cnt_q + 16'd1;
      end else begin
         pair_cnt_q <= pair_cnt_q;
      end
   end

   rle_pair_fifo #(
      .WIDTH (PW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_n_i (push_n_s),
      .wdata0_i (pair0_s),
      .wdata1_i (pair1_s),
      .pop_i    (pop_s),
      .rdata_o  (head_s),
      .empty_o  (empty_s),
      .free_o   (free_s)
   );

endmodule

// File: tb/tb_rle_stream_encoder.sv
// Scoreboard bench: a run-based reference model queues expected pairs,
// a monitor compares every popped pair in order.
module tb_rle_stream_encoder;

   localparam int DW   = 8;
   localparam int CW   = 8;
   localparam int MAXR = 255;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          in_last;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [CW+DW-1:0] out_data;
   logic          out_last;
   logic [15:0]   pair_cnt;

   always #5 clk = ~clk;

   rle_stream_encoder #(.DATA_W(DW), .CNT_W(CW), .FIFO_DEPTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .pair_cnt  (pair_cnt)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int pops  = 0;
   logic [CW+DW:0] exp_q[$];
   bit  or_want = 1'b1;

   // reference model: the open run as plain integers
   bit m_open = 0;
   int m_val  = 0;
   int m_cnt  = 0;

   task automatic check(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic emit(input int c, input int v, input bit l);
      logic [CW+DW:0] p;
      p = {l, CW'(c), DW'(v)};
      exp_q.push_back(p);
   endtask

   // One accepted symbol: extend the run, or close it and start another.
   task automatic model_beat(input int d, input bit l);
      if (m_open && d == m_val && m_cnt < MAXR) begin
         m_cnt++;
      end else begin
         if (m_open) emit(m_cnt, m_val, 1'b0);
         m_open = 1;
         m_val  = d;
         m_cnt  = 1;
      end
      if (l) begin
         emit(m_cnt, m_val, 1'b1);
         m_open = 0;
      end
   endtask

   task automatic model_flush();
      if (m_open) begin
         emit(m_cnt, m_val, 1'b1);
         m_open = 0;
      end
   endtask

   // Drive one cycle just after the rising edge; decide acceptance at the falling edge.
   task automatic cycle(input bit v, input int d, input bit l, input bit f, output bit acc);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = DW'(d);
      in_last   = l;
      flush     = f;
      out_ready = or_want;
      @(negedge clk);
      acc = v && in_ready;
      if (acc) model_beat(d, l | f);
      else if (f) model_flush();
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b0, a);
   endtask

   task automatic send(input int d, input bit l);
      bit a;
      a = 1'b0;
      for (int t = 0; t < 200 && !a; t++) cycle(1'b1, d, l, 1'b0, a);
      if (!a) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: symbol 0x%0h never accepted", d);
      end
   endtask

   // Monitor: every pop must match the oldest expected pair.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pair_unexpected: got 0x%0h, expected none", {out_last, out_data});
         end else begin
            check("pair", {out_last, out_data}, exp_q.pop_front());
         end
         check("pair_cnt", pair_cnt, pops & 16'hFFFF);
         pops++;
      end
   end

   initial begin
      bit acc;
      int nacc;
      int sym;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      flush = 1'b0; out_ready = 1'b1;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
      check("rst_pair_cnt", pair_cnt, 0);
      rst_n = 1'b1;
      idle(1);
      check("ready_after_release", in_ready, 1);

      // basic runs
      send(5, 0); send(5, 0); send(5, 0); send(7, 0); send(7, 0); send(9, 1);
      idle(3);
      check("basic_drained", exp_q.size(), 0);
      check("basic_pair_cnt", pair_cnt, 3);

      // saturation plus two-push beat
      for (int i = 0; i < 300; i++) send(8'h0A, 0);
      send(8'h0F, 1);
      idle(4);
      check("sat_drained", exp_q.size(), 0);
      check("sat_pair_cnt", pair_cnt, 6);

      // flush closes an open run one cycle later; flush in idle does nothing
      send(8'h0A, 0); send(8'h0A, 0); send(8'h0A, 0);
      idle(3);
      check("no_pair_before_flush", out_valid, 0);
      cycle(1'b0, 0, 1'b0, 1'b1, acc);
      idle(1);
      check("flush_latency", out_valid, 1);
      cycle(1'b0, 0, 1'b0, 1'b1, acc);
      idle(1);
      check("idle_flush_no_push", out_valid, 0);
      check("flush_pair_cnt", pair_cnt, 7);

      // backpressure: 7 pairs pushed, run open, then in_ready drops
      or_want = 1'b0;
      idle(1);
      nacc = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, i + 1, 1'b0, 1'b0, acc);
         if (acc) nacc++;
      end
      check("bp_accepted", nacc, 8);
      check("bp_in_ready", in_ready, 0);
      cycle(1'b0, 0, 1'b0, 1'b1, acc);
      idle(1);
      check("bp_full_ready", in_ready, 0);
      or_want = 1'b1;
      idle(12);
      check("bp_drained", exp_q.size(), 0);
      check("bp_pair_cnt", pair_cnt, 15);

      // asynchronous reset mid-cycle discards pending pairs and the open run
      or_want = 1'b0;
      send(5, 0); send(6, 0); send(7, 0); send(7, 0);
      idle(1);
      check("pre_reset_valid", out_valid, 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", out_valid, 0);
      check("async_rst_pair_cnt", pair_cnt, 0);
      exp_q.delete();
      pops   = 0;
      m_open = 0;
      @(negedge clk);
      rst_n   = 1'b1;
      or_want = 1'b1;
      idle(1);
      check("ready_after_rerelease", in_ready, 1);
      send(8'h0C, 1);
      idle(3);
      check("post_rst_drained", exp_q.size(), 0);
      check("post_rst_pair_cnt", pair_cnt, 1);

      // randomized traffic with backpressure, frame ends and flush pulses
      sym = 0;
      for (int i = 0; i < 4000; i++) begin
         or_want = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 3) == 0) sym = $urandom_range(0, 2);
         cycle($urandom_range(0, 3) != 0, sym, $urandom_range(0, 15) == 0,
               $urandom_range(0, 31) == 0, acc);
      end

      // close and drain
      or_want = 1'b1;
      cycle(1'b0, 0, 1'b0, 1'b1, acc);
      for (int t = 0; t < 100 && exp_q.size() != 0; t++) idle(1);
      check("final_drained", exp_q.size(), 0);
      idle(2);
      check("final_out_valid", out_valid, 0);
      check("final_pair_cnt", pair_cnt, pops & 16'hFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
